imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Purpose: loads a little-endian byte stream into instruction memory as words and holds the core in reset until the load is done.
// Latency: one word per 5 cycles (4 byte cycles + 1 write cycle); done rises 2 cycles after the final byte is accepted.
// Backpressure: byte_ready is high only while collecting bytes; it drops during the write cycle and outside a load.
module imem_loader #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_SIZE      = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(MEM_SIZE):0]  num_words,
    input  logic                       byte_valid,
    input  logic [7:0]                 byte_data,
    output logic                       byte_ready,
    output logic                       mem_we,
    output logic [ADDRESS_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic                       cpu_rst
);

    localparam int NW_W   = $clog2(MEM_SIZE) + 1;
    localparam int WIDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic [NW_W-1:0]         num_words_q;
    logic [WIDX_W-1:0]       word_idx;
    logic [BIDX_W-1:0]       byte_idx;
    logic [DATA_WIDTH-1:0]   word_buf;

    logic                    byte_take;
    logic                    num_ok;
    logic                    last_byte;
    logic                    last_word;
    logic [DATA_WIDTH-1:0]   next_word;

    // A byte moves only on a valid/ready handshake; ready is already restricted to RECV.
    assign byte_take = byte_valid && byte_ready;
    // Legal counts are 1..MEM_SIZE, which also bounds word_idx to MEM_SIZE-1.
    assign num_ok    = (num_words != '0) && (num_words <= NW_W'(MEM_SIZE));
    assign last_byte = (byte_idx == BIDX_W'(BYTES - 1));
    assign last_word = (NW_W'(word_idx) == (num_words_q - NW_W'(1)));
    // Shifting in from the top leaves the first byte of a word in bits [7:0] after BYTES shifts.
    assign next_word = {byte_data, word_buf[DATA_WIDTH-1:8]};

    // Load sequencer: every output is a register updated on the state transition that precedes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            num_words_q <= '0;
            word_idx    <= '0;
            byte_idx    <= '0;
            word_buf    <= '0;
            byte_ready  <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            cpu_rst     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_ok) begin
                            num_words_q <= num_words;
                            word_idx    <= '0;
                            byte_idx    <= '0;
                            done        <= 1'b0;
                            error       <= 1'b0;
                            busy        <= 1'b1;
                            cpu_rst     <= 1'b1;
                            byte_ready  <= 1'b1;
                            state       <= RECV;
                        end else begin
                            error <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                RECV: begin
                    if (byte_take) begin
                        word_buf <= next_word;
                        if (last_byte) begin
                            // Stop accepting so the byte offered during the write cycle stays with the source.
                            byte_ready <= 1'b0;
                            byte_idx   <= '0;
                            mem_we     <= 1'b1;
                            mem_addr   <= ADDRESS_WIDTH'({word_idx, 2'b00});
                            mem_wdata  <= next_word;
                            state      <= WRITE;
                        end else begin
                            byte_idx <= byte_idx + BIDX_W'(1);
                        end
                    end
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    if (last_word) begin
                        state <= DONE;
                    end else begin
                        word_idx   <= word_idx + WIDX_W'(1);
                        byte_idx   <= '0;
                        byte_ready <= 1'b1;
                        state      <= RECV;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    cpu_rst <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Purpose: self-checking bench for imem_loader using a byte-stream-to-word reference model.
// Latency: drives inputs on the falling edge and samples outputs on the falling edge or 1 time unit after the rising edge.
// Backpressure: the byte source honours byte_ready and inserts random byte_valid gaps.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  num_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_rst;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_rst    (cpu_rst)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    wr_t         obs_q[$];
    wr_t         exp_q[$];
    logic [7:0]  src_q[$];
    int          src_pos;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count used to measure write spacing.
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Record every cycle in which the write strobe is high.
    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) obs_q.push_back('{addr: mem_addr, data: mem_wdata, cyc: cyc_cnt});
    end

    // Reference model: word k is bytes 4k..4k+3 of the source, first byte least significant, at byte address 4k.
    task automatic build_expected(input int first, input int nwords);
        exp_q.delete();
        for (int k = 0; k < nwords; k++) begin
            wr_t w;
            w.addr = 32'(k * 4);
            w.data = {src_q[first + 4*k + 3], src_q[first + 4*k + 2],
                      src_q[first + 4*k + 1], src_q[first + 4*k]};
            w.cyc  = 0;
            exp_q.push_back(w);
        end
    endtask

    task automatic do_start(input logic [8:0] nw);
        @(negedge clk);
        start     = 1'b1;
        num_words = nw;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Offer n bytes from src_q honouring byte_ready; ok reports whether all were taken within the budget.
    task automatic feed_bytes(input int n, input int gap_pct, output bit ok);
        int  sent = 0;
        int  cyc  = 0;
        logic rdy;
        while (sent < n && cyc < 20 * n + 50) begin
            @(negedge clk);
            if (int'($urandom_range(99)) < gap_pct) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
            end else begin
                byte_valid = 1'b1;
                byte_data  = src_q[src_pos];
            end
            rdy = byte_ready;
            @(posedge clk);
            if (byte_valid && rdy) begin
                sent++;
                src_pos++;
            end
            cyc++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        ok = (sent == n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (cpu_rst !== 1'b1)     begin errors++; $display("FAIL reset_cpu_rst: got %b expected 1", cpu_rst); end
        checks++; if (byte_ready !== 1'b0)  begin errors++; $display("FAIL reset_byte_ready: got %b expected 0", byte_ready); end
        checks++; if (mem_we !== 1'b0)      begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 32'h0)   begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0)  begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (error !== 1'b0)       begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
        rst = 1'b0;
        // Idle FSM: a bare byte must not be consumed and nothing starts.
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        checks++; if (byte_ready !== 1'b0 || busy !== 1'b0 || obs_q.size() != 0) begin
            errors++; $display("FAIL reset_idle: got ready=%b busy=%b writes=%0d expected 0 0 0", byte_ready, busy, obs_q.size());
        end
    endtask

    task automatic test_two_word();
        bit ok;
        bit got_done;
        obs_q.delete();
        src_q = '{8'h13, 8'h05, 8'h50, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};
        src_pos = 0;
        do_start(9'd2);
        checks++; if (busy !== 1'b1 || cpu_rst !== 1'b1 || byte_ready !== 1'b1) begin
            errors++; $display("FAIL two_word_started: got busy=%b cpu_rst=%b ready=%b expected 1 1 1", busy, cpu_rst, byte_ready);
        end
        feed_bytes(8, 0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL two_word_feed: got stalled expected 8 bytes accepted"); end
        got_done = 1'b0;
        for (int c = 0; c < 20 && !got_done; c++) begin @(negedge clk); got_done = done; end
        checks++; if (!got_done) begin errors++; $display("FAIL two_word_done: got done=0 expected 1"); end
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL two_word_count: got %0d expected 2", obs_q.size()); end
        if (obs_q.size() == 2) begin
            checks++; if (obs_q[0].addr !== 32'h0 || obs_q[0].data !== 32'h00500513) begin
                errors++; $display("FAIL two_word_w0: got %h/%h expected 00000000/00500513", obs_q[0].addr, obs_q[0].data);
            end
            checks++; if (obs_q[1].addr !== 32'h4 || obs_q[1].data !== 32'h00B505B3) begin
                errors++; $display("FAIL two_word_w1: got %h/%h expected 00000004/00b505b3", obs_q[1].addr, obs_q[1].data);
            end
        end
        checks++; if (cpu_rst !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL two_word_status: got cpu_rst=%b busy=%b expected 0 0", cpu_rst, busy);
        end
        repeat (5) @(negedge clk);
        checks++; if (done !== 1'b1 || cpu_rst !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL two_word_persist: got done=%b cpu_rst=%b we=%b expected 1 0 0", done, cpu_rst, mem_we);
        end
        checks++; if (mem_addr !== 32'h4 || mem_wdata !== 32'h00B505B3) begin
            errors++; $display("FAIL two_word_hold: got %h/%h expected 00000004/00b505b3", mem_addr, mem_wdata);
        end
    endtask

    task automatic test_full_load();
        bit ok;
        bit got_done;
        obs_q.delete();
        src_q.delete();
        for (int i = 0; i < 256 * 4; i++) src_q.push_back(8'($urandom));
        src_pos = 0;
        build_expected(0, 256);
        do_start(9'd256);
        feed_bytes(256 * 4, 0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_feed: got stalled at byte %0d expected 1024", src_pos); end
        got_done = 1'b0;
        for (int c = 0; c < 20 && !got_done; c++) begin @(negedge clk); got_done = done; end
        checks++; if (!got_done) begin errors++; $display("FAIL full_done: got done=0 expected 1"); end
        repeat (10) @(negedge clk);
        checks++; if (obs_q.size() != 256) begin errors++; $display("FAIL full_count: got %0d expected 256", obs_q.size()); end
        for (int i = 0; i < 256 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
                errors++; $display("FAIL full_w%0d: got %h/%h expected %h/%h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        if (obs_q.size() == 256) begin
            checks++; if (obs_q[255].addr !== 32'h000003FC) begin
                errors++; $display("FAIL full_last_addr: got %h expected 000003fc", obs_q[255].addr);
            end
            checks++; if (obs_q[255].cyc - obs_q[0].cyc != 255 * 5) begin
                errors++; $display("FAIL full_throughput: got %0d cycles expected %0d", obs_q[255].cyc - obs_q[0].cyc, 255 * 5);
            end
        end
    endtask

    task automatic test_stream_gaps();
        for (int t = 0; t < 4; t++) begin
            bit ok;
            bit got_done;
            int nw;
            nw = int'($urandom_range(1, 9));
            obs_q.delete();
            src_q.delete();
            for (int i = 0; i < nw * 4; i++) src_q.push_back(8'($urandom));
            src_pos = 0;
            build_expected(0, nw);
            do_start(9'(nw));
            feed_bytes(nw * 4, 40, ok);
            checks++; if (!ok) begin errors++; $display("FAIL gaps%0d_feed: got %0d bytes expected %0d", t, src_pos, nw * 4); end
            got_done = 1'b0;
            for (int c = 0; c < 20 && !got_done; c++) begin @(negedge clk); got_done = done; end
            checks++; if (!got_done) begin errors++; $display("FAIL gaps%0d_done: got done=0 expected 1", t); end
            checks++; if (obs_q.size() != nw) begin errors++; $display("FAIL gaps%0d_count: got %0d expected %0d", t, obs_q.size(), nw); end
            for (int i = 0; i < nw && i < obs_q.size(); i++) begin
                checks++; if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
                    errors++; $display("FAIL gaps%0d_w%0d: got %h/%h expected %h/%h", t, i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        bit ok1;
        bit ok2;
        bit got_done;
        obs_q.delete();
        src_q.delete();
        for (int i = 0; i < 8; i++) src_q.push_back(8'($urandom));
        src_pos = 0;
        build_expected(0, 2);
        do_start(9'd2);
        feed_bytes(3, 0, ok1);
        do_start(9'd0);
        checks++; if (error !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL busy_start_ignored: got error=%b busy=%b expected 0 1", error, busy);
        end
        feed_bytes(5, 0, ok2);
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL busy_feed: got %0d bytes expected 8", src_pos); end
        got_done = 1'b0;
        for (int c = 0; c < 20 && !got_done; c++) begin @(negedge clk); got_done = done; end
        checks++; if (!got_done || obs_q.size() != 2) begin
            errors++; $display("FAIL busy_complete: got done=%b writes=%0d expected 1 2", got_done, obs_q.size());
        end
        for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
                errors++; $display("FAIL busy_w%0d: got %h/%h expected %h/%h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_illegal();
        logic [8:0] bad [2];
        bad[0] = 9'd0;
        bad[1] = 9'd257;
        for (int t = 0; t < 2; t++) begin
            obs_q.delete();
            byte_valid = 1'b1;
            byte_data  = 8'h5A;
            do_start(bad[t]);
            checks++; if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL illegal%0d_flags: got error=%b busy=%b done=%b expected 1 0 0", bad[t], error, busy, done);
            end
            repeat (6) @(negedge clk);
            byte_valid = 1'b0;
            checks++; if (error !== 1'b1 || byte_ready !== 1'b0 || obs_q.size() != 0) begin
                errors++; $display("FAIL illegal%0d_hold: got error=%b ready=%b writes=%0d expected 1 0 0", bad[t], error, byte_ready, obs_q.size());
            end
        end
    endtask

    task automatic test_reset_mid_word();
        bit ok;
        bit got_done;
        obs_q.delete();
        src_q.delete();
        for (int i = 0; i < 6; i++) src_q.push_back(8'($urandom));
        src_pos = 0;
        do_start(9'd1);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL midrst_error_cleared: got %b expected 0", error); end
        feed_bytes(2, 0, ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (obs_q.size() != 0 || cpu_rst !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_state: got writes=%0d cpu_rst=%b busy=%b expected 0 1 0", obs_q.size(), cpu_rst, busy);
        end
        build_expected(2, 1);
        do_start(9'd1);
        feed_bytes(4, 25, ok);
        got_done = 1'b0;
        for (int c = 0; c < 20 && !got_done; c++) begin @(negedge clk); got_done = done; end
        checks++; if (!ok || !got_done || obs_q.size() != 1) begin
            errors++; $display("FAIL midrst_reload: got ok=%b done=%b writes=%0d expected 1 1 1", ok, got_done, obs_q.size());
        end
        if (obs_q.size() >= 1) begin
            checks++; if (obs_q[0].addr !== 32'h0 || obs_q[0].data !== exp_q[0].data) begin
                errors++; $display("FAIL midrst_word: got %h/%h expected 00000000/%h", obs_q[0].addr, obs_q[0].data, exp_q[0].data);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        num_words  = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        test_reset();
        test_two_word();
        test_illegal();
        test_full_load();
        test_stream_gaps();
        test_start_while_busy();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
